rf_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file (negedge write, r0 hardwired to zero).
- Shares that port between two writers: the in-order pipeline writeback stage (fixed timing, priority) and a long-latency unit (loads/mul-div, valid/ready handshake).
- Keeps a per-register pending-write scoreboard so the hazard unit can stall readers of registers still owed a long-latency result.
- Forces a one-cycle pipeline bubble when the long-latency unit starves.

---
 rtl/rf_wb_arbiter_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 37 +++
 rtl/rf_wb_arbiter.sv | 109 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice:
// register file geometry and the arbiter FSM state encoding.
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register marks a long-latency
// result that has been issued but not yet written back.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_reg,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_reg,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  rs_busy,
  output logic                  rt_busy
);

  logic [NUM_REGS-1:0] pending;

  // Clear on writeback grant, then set on issue so a same-cycle re-issue wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      if (clr_en) begin
        pending[clr_reg] <= 1'b0;
      end
      if (set_en && (set_reg != '0)) begin
        pending[set_reg] <= 1'b1;
      end
    end
  end

  assign rs_busy = rst && (rs_addr != '0) && pending[rs_addr];
  assign rt_busy = rst && (rt_addr != '0) && pending[rt_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: the pipeline writeback stage has
// priority, the long-latency unit takes free cycles, and a run of
// STARVE_LIMIT blocked cycles forces a one-cycle pipeline bubble.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wreg,
  input  logic [31:0] pipe_wdata,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_reg,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wreg,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_wreg,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_busy,
  output logic        rt_busy
);

  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             pipe_req;
  logic             ready_raw;
  logic             blocked;
  logic             grant;

  assign pipe_req  = pipe_we && (pipe_wreg != 5'd0);
  assign ready_raw = (state == FORCE) || !pipe_req;
  assign blocked   = lu_valid && !ready_raw;
  assign lu_ready  = rst && ready_raw;
  assign stall_pipe = rst && (state == FORCE);
  assign grant     = lu_valid && lu_ready;

  // wait_cnt holds the number of consecutive blocked cycles seen so far,
  // including the current one once it is counted.
  assign next_cnt = (state == IDLE) ? CNT_W'(1) : (wait_cnt + CNT_W'(1));

  // Starvation FSM: count blocked cycles and take one FORCE cycle at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (blocked) begin
            wait_cnt <= next_cnt;
            state    <= (next_cnt == CNT_W'(STARVE_LIMIT)) ? FORCE : WAIT;
          end else begin
            wait_cnt <= '0;
            state    <= IDLE;
          end
        end
        FORCE: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Write port mux: pipeline first unless bubbling, then the long unit.
  always_comb begin
    rf_we    = 1'b0;
    rf_wreg  = 5'd0;
    rf_wdata = 32'd0;
    if (rst) begin
      if ((state != FORCE) && pipe_req) begin
        rf_we    = 1'b1;
        rf_wreg  = pipe_wreg;
        rf_wdata = pipe_wdata;
      end else if (lu_valid) begin
        rf_we    = (lu_wreg != 5'd0);
        rf_wreg  = lu_wreg;
        rf_wdata = lu_wdata;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (lu_issue),
    .set_reg (lu_issue_reg),
    .clr_en  (grant),
    .clr_reg (lu_wreg),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_busy (rs_busy),
    .rt_busy (rt_busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a STARVE_LIMIT=4 instance and a
// STARVE_LIMIT=1 instance share stimulus; a reference model pushes the
// expected outputs per cycle and they are popped and compared at negedge.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_wreg = 5'd0;
  logic [31:0] pipe_wdata = 32'd0;
  logic        lu_issue = 1'b0;
  logic [4:0]  lu_issue_reg = 5'd0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_wreg = 5'd0;
  logic [31:0] lu_wdata = 32'd0;
  logic [4:0]  rs_addr = 5'd0;
  logic [4:0]  rt_addr = 5'd0;

  logic        lu_ready, stall_pipe, rf_we, rs_busy, rt_busy;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
  logic        lu_ready1, stall_pipe1, rf_we1, rs_busy1, rt_busy1;
  logic [4:0]  rf_wreg1;
  logic [31:0] rf_wdata1;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        ready;
    logic        stall;
    logic        rsb;
    logic        rtb;
    logic        ready1;
    logic        stall1;
  } exp_t;

  exp_t        expq[$];
  int          compared = 0;
  int          mismatched = 0;

  logic [31:0] m_pending = 32'd0;
  int          m_streak4 = 0;
  int          m_streak1 = 0;
  bit          m_force4 = 1'b0;
  bit          m_force1 = 1'b0;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wreg(pipe_wreg), .pipe_wdata(pipe_wdata),
    .lu_issue(lu_issue), .lu_issue_reg(lu_issue_reg),
    .lu_valid(lu_valid), .lu_wreg(lu_wreg), .lu_wdata(lu_wdata),
    .lu_ready(lu_ready), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy)
  );

  rf_wb_arbiter #(.STARVE_LIMIT(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wreg(pipe_wreg), .pipe_wdata(pipe_wdata),
    .lu_issue(lu_issue), .lu_issue_reg(lu_issue_reg),
    .lu_valid(lu_valid), .lu_wreg(lu_wreg), .lu_wdata(lu_wdata),
    .lu_ready(lu_ready1), .stall_pipe(stall_pipe1),
    .rf_we(rf_we1), .rf_wreg(rf_wreg1), .rf_wdata(rf_wdata1),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_busy(rs_busy1), .rt_busy(rt_busy1)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, optionally pulse reset mid-cycle,
  // push the model's expectation, compare at negedge, advance the model.
  task automatic applyStimulus(input string name,
                               input logic pwe, input logic [4:0] pwreg, input logic [31:0] pwdata,
                               input logic lv, input logic [4:0] lwreg, input logic [31:0] lwdata,
                               input logic iss, input logic [4:0] issreg,
                               input logic [4:0] rs, input logic [4:0] rt, input bit do_rst);
    exp_t e;
    exp_t got;
    bit   preq;
    bit   blocked4;
    bit   blocked1;
    pipe_we = pwe;  pipe_wreg = pwreg;  pipe_wdata = pwdata;
    lu_valid = lv;  lu_wreg = lwreg;    lu_wdata = lwdata;
    lu_issue = iss; lu_issue_reg = issreg;
    rs_addr = rs;   rt_addr = rt;
    if (do_rst) begin
      #1 rst = 1'b0;
      #1;
      checkOutput({name, ".rst.rf_we"},      32'(rf_we),       32'd0);
      checkOutput({name, ".rst.rf_wreg"},    32'(rf_wreg),     32'd0);
      checkOutput({name, ".rst.rf_wdata"},   rf_wdata,         32'd0);
      checkOutput({name, ".rst.lu_ready"},   32'(lu_ready),    32'd0);
      checkOutput({name, ".rst.stall_pipe"}, 32'(stall_pipe),  32'd0);
      checkOutput({name, ".rst.rs_busy"},    32'(rs_busy),     32'd0);
      checkOutput({name, ".rst.stall1"},     32'(stall_pipe1), 32'd0);
      checkOutput({name, ".rst.ready1"},     32'(lu_ready1),   32'd0);
      m_pending = 32'd0;
      m_streak4 = 0; m_streak1 = 0;
      m_force4 = 1'b0; m_force1 = 1'b0;
      #1 rst = 1'b1;
    end
    preq     = pwe && (pwreg != 5'd0);
    e.ready  = m_force4 || !preq;
    e.stall  = m_force4;
    e.ready1 = m_force1 || !preq;
    e.stall1 = m_force1;
    if (!m_force4 && preq) begin
      e.we = 1'b1; e.wreg = pwreg; e.wdata = pwdata;
    end else if (lv) begin
      e.we = (lwreg != 5'd0); e.wreg = lwreg; e.wdata = lwdata;
    end else begin
      e.we = 1'b0; e.wreg = 5'd0; e.wdata = 32'd0;
    end
    e.rsb = (rs != 5'd0) && m_pending[rs];
    e.rtb = (rt != 5'd0) && m_pending[rt];
    expq.push_back(e);

    @(negedge clk);
    got = expq.pop_front();
    checkOutput({name, ".rf_we"},      32'(rf_we),       32'(got.we));
    checkOutput({name, ".rf_wreg"},    32'(rf_wreg),     32'(got.wreg));
    checkOutput({name, ".rf_wdata"},   rf_wdata,         got.wdata);
    checkOutput({name, ".lu_ready"},   32'(lu_ready),    32'(got.ready));
    checkOutput({name, ".stall_pipe"}, 32'(stall_pipe),  32'(got.stall));
    checkOutput({name, ".rs_busy"},    32'(rs_busy),     32'(got.rsb));
    checkOutput({name, ".rt_busy"},    32'(rt_busy),     32'(got.rtb));
    checkOutput({name, ".lim1.ready"}, 32'(lu_ready1),   32'(got.ready1));
    checkOutput({name, ".lim1.stall"}, 32'(stall_pipe1), 32'(got.stall1));

    @(posedge clk);
    if (lv && e.ready) m_pending[lwreg] = 1'b0;
    if (iss && (issreg != 5'd0)) m_pending[issreg] = 1'b1;
    blocked4 = lv && !e.ready;
    blocked1 = lv && !e.ready1;
    m_streak4 = blocked4 ? m_streak4 + 1 : 0;
    m_streak1 = blocked1 ? m_streak1 + 1 : 0;
    m_force4 = (m_streak4 == 4);
    m_force1 = (m_streak1 == 1);
    if (m_force4) m_streak4 = 0;
    if (m_force1) m_streak1 = 0;
    #1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence covering priority, handshake, scoreboard and starvation.
  initial begin
    pipe_we = 1'b1; pipe_wreg = 5'd5; pipe_wdata = 32'hA5A5_0001;
    lu_valid = 1'b1; lu_wreg = 5'd6; lu_issue = 1'b1; lu_issue_reg = 5'd3;
    rs_addr = 5'd3;
    #2;
    checkOutput("reset.rf_we",      32'(rf_we),      32'd0);
    checkOutput("reset.rf_wreg",    32'(rf_wreg),    32'd0);
    checkOutput("reset.rf_wdata",   rf_wdata,        32'd0);
    checkOutput("reset.lu_ready",   32'(lu_ready),   32'd0);
    checkOutput("reset.stall_pipe", 32'(stall_pipe), 32'd0);
    checkOutput("reset.rs_busy",    32'(rs_busy),    32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    lu_issue = 1'b0; lu_valid = 1'b0; pipe_we = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("nocont",  1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus("issue8",  1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,      1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    applyStimulus("busy8a",  1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 5'd8, 5'd8, 1'b0);
    applyStimulus("busy8b",  1'b1, 5'd2, 32'h0000_0222, 1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 5'd8, 5'd0, 1'b0);
    applyStimulus("lu8",     1'b0, 5'd0, 32'd0,         1'b1, 5'd8, 32'h1234,   1'b0, 5'd0, 5'd8, 5'd0, 1'b0);
    applyStimulus("clr8",    1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 5'd8, 5'd8, 1'b0);
    applyStimulus("pipe_r0", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'h33,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus("lu_r0",   1'b0, 5'd0, 32'd0,         1'b1, 5'd0, 32'h77,     1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus("iss9",    1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,      1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    applyStimulus("setwins", 1'b0, 5'd0, 32'd0,         1'b1, 5'd9, 32'h99,     1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    applyStimulus("busy9",   1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 5'd9, 5'd0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus($sformatf("starve%0d", i + 1), 1'b1, 5'd4, 32'h4000 + 32'(i),
                    1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 5'd9, 5'd4, 1'b0);
    end
    applyStimulus("quiet",   1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 5'd9, 5'd0, 1'b0);

    applyStimulus("iss7",    1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,      1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("pre_rst%0d", i + 1), 1'b1, 5'd4, 32'h7000 + 32'(i),
                    1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
    end
    applyStimulus("rst_mid", 1'b1, 5'd4, 32'h7100,      1'b1, 5'd7, 32'h7777,   1'b0, 5'd0, 5'd7, 5'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("post_rst%0d", i + 1), 1'b1, 5'd4, 32'h7200 + 32'(i),
                    1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
    end
    applyStimulus("final",   1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 5'd7, 5'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
